// File: rtl/ds_arb_pkg.sv
// ds_arb_pkg
// Shared types and helpers for the DataStream burst arbiters.
//   arb_state_e : two-state arbitration FSM encoding (IDLE / BUSY)
//   cnt_width() : width of a 0..burst-1 transfer counter, never below 1 bit
package ds_arb_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_e;

  // $clog2(1) is 0, which cannot size a vector, so clamp to one bit.
  function automatic int cnt_width(input int burst);
    return (burst > 1) ? $clog2(burst) : 1;
  endfunction

endpackage

// File: rtl/ds_rr_pick.sv
// ds_rr_pick
// Purely combinational round-robin picker.
// Ports:
//   req_i  [PORTS]          request vector, one bit per port
//   last_i [$clog2(PORTS)]  index granted most recently
//   gnt_o  [$clog2(PORTS)]  first requesting port after last_i (wrapping)
//   any_o                   at least one request bit is set
// The search starts at last_i+1, so the port just served has the lowest
// priority on the next pick.
module ds_rr_pick #(
  parameter int PORTS = 4
) (
  input  logic [PORTS-1:0]         req_i,
  input  logic [$clog2(PORTS)-1:0] last_i,
  output logic [$clog2(PORTS)-1:0] gnt_o,
  output logic                     any_o
);

  localparam int SW = $clog2(PORTS);

  always_comb begin
    int   idx;
    logic found;
    idx   = 0;
    found = 1'b0;
    gnt_o = '0;
    // off = PORTS lands back on last_i itself, so a lone requester that
    // was just served is still found.
    for (int off = 1; off <= PORTS; off++) begin
      idx = (int'(last_i) + off) % PORTS;
      if (!found && req_i[idx]) begin
        gnt_o = idx[SW-1:0];
        found = 1'b1;
      end
    end
    any_o = found;
  end

endmodule

// File: rtl/ds_burst_arbiter.sv
// ds_burst_arbiter
// Round-robin arbiter sharing one DataStream sink between PORTS sources.
// A grant lasts up to BURST words and ends early when the granted source
// drops valid. Every release is followed by one IDLE arbitration cycle.
// The datapath is a combinational pass-through; no words are stored here.
// Ports:
//   clk, reset      clock, synchronous active-high reset
//   i_dat           PORTS*DWIDTH inbound data, port k at [k*DWIDTH +: DWIDTH]
//   i_val / i_rdy   inbound handshake, one bit per port
//   o_dat           data of the granted port (also driven while IDLE)
//   o_sel           index of the granted port
//   o_val / o_rdy   outbound handshake
module ds_burst_arbiter
  import ds_arb_pkg::*;
#(
  parameter int DWIDTH = 8,
  parameter int PORTS  = 4,
  parameter int BURST  = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [PORTS*DWIDTH-1:0]   i_dat,
  input  logic [PORTS-1:0]          i_val,
  output logic [PORTS-1:0]          i_rdy,
  output logic [DWIDTH-1:0]         o_dat,
  output logic [$clog2(PORTS)-1:0]  o_sel,
  output logic                      o_val,
  input  logic                      o_rdy
);

  localparam int SW = $clog2(PORTS);
  localparam int CW = cnt_width(BURST);
  localparam logic [CW-1:0] CNT_LAST = CW'(BURST - 1);
  localparam logic [SW-1:0] LAST_RST = SW'(PORTS - 1);

  arb_state_e    state_q, state_d;
  logic [SW-1:0] gnt_q,   gnt_d;
  logic [SW-1:0] last_q,  last_d;
  logic [CW-1:0] cnt_q,   cnt_d;

  logic [SW-1:0] pick_gnt;
  logic          pick_any;
  logic          busy;
  logic          gnt_val;
  logic          xfer;
  logic          release_grant;

  ds_rr_pick #(
    .PORTS (PORTS)
  ) u_pick (
    .req_i  (i_val),
    .last_i (last_q),
    .gnt_o  (pick_gnt),
    .any_o  (pick_any)
  );

  assign busy    = (state_q == BUSY);
  assign gnt_val = i_val[gnt_q];
  assign xfer    = busy && gnt_val && o_rdy;
  // Either the source went idle (no transfer this cycle) or the final word
  // of the burst is moving. Backpressure alone never ends a grant.
  assign release_grant = busy && (!gnt_val || (xfer && (cnt_q == CNT_LAST)));

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      last_q  <= LAST_RST;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (pick_any) begin
          gnt_d   = pick_gnt;
          state_d = BUSY;
        end
      end
      BUSY: begin
        if (release_grant) begin
          state_d = IDLE;
          last_d  = gnt_q;
          cnt_d   = '0;
        end else if (xfer) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    o_dat = i_dat[int'(gnt_q) * DWIDTH +: DWIDTH];
    o_sel = gnt_q;
    o_val = busy && gnt_val;
    i_rdy = '0;
    if (busy) begin
      i_rdy[gnt_q] = o_rdy;
    end
  end

endmodule

// File: tb/tb_ds_burst_arbiter.sv
// Bench for ds_burst_arbiter. Four instances with BURST = 4, 1, 16, 8 each
// have their own sources; every source emits {port, seq} and advances seq
// on its own handshake.
module tb_ds_burst_arbiter;

  localparam int NI = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst   [NI];
  logic [3:0] req   [NI];
  logic       ordy  [NI];
  wire [31:0] dat_w [NI];
  wire [3:0]  irdy_w[NI];
  wire [7:0]  odat_w[NI];
  wire [1:0]  osel_w[NI];
  wire        oval_w[NI];

  logic [5:0] seq     [NI][4] = '{default: '{default: 6'd0}};
  logic [5:0] exp_seq [NI][4];

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [3:0] req;
    int         tok;   // >=0 transfer from that port, -1 IDLE, -2 granted source idle
  } step_t;

  step_t plan_q [$];
  int    grant_q[$];

  for (genvar gi = 0; gi < NI; gi++) begin : g_dut
    localparam int BL = (gi == 0) ? 4 : (gi == 1) ? 1 : (gi == 2) ? 16 : 8;
    assign dat_w[gi] = {2'd3, seq[gi][3], 2'd2, seq[gi][2], 2'd1, seq[gi][1], 2'd0, seq[gi][0]};
    ds_burst_arbiter #(
      .DWIDTH (8),
      .PORTS  (4),
      .BURST  (BL)
    ) u_dut (
      .clk   (clk),
      .reset (rst[gi]),
      .i_dat (dat_w[gi]),
      .i_val (req[gi]),
      .i_rdy (irdy_w[gi]),
      .o_dat (odat_w[gi]),
      .o_sel (osel_w[gi]),
      .o_val (oval_w[gi]),
      .o_rdy (ordy[gi])
    );
  end

  // Sources: next word once the current one is taken.
  always @(posedge clk) begin
    for (int i = 0; i < NI; i++)
      for (int p = 0; p < 4; p++)
        if (req[i][p] && irdy_w[i][p]) seq[i][p] <= seq[i][p] + 6'd1;
  end

  function automatic logic [7:0] exp_word(input int i, input int p);
    logic [1:0] pp;
    pp = 2'(p);
    return {pp, exp_seq[i][p]};
  endfunction

  task automatic add(input logic [3:0] r, input int t, input int n);
    step_t s;
    s.req = r;
    s.tok = t;
    repeat (n) plan_q.push_back(s);
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clk);
    for (int i = 0; i < NI; i++) begin
      rst[i]  = 1'b0;
      ordy[i] = 1'b1;
    end
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      #1;
      for (int i = 0; i < NI; i++) begin
        total++;
        if (oval_w[i] !== 1'b0 || irdy_w[i] !== 4'b0000 || osel_w[i] !== 2'd0) begin
          bad++;
          $display("FAIL reset inst%0d cyc%0d: o_val=%b i_rdy=%b o_sel=%0d, want 0/0000/0",
                   i, c, oval_w[i], irdy_w[i], osel_w[i]);
        end
      end
    end
  endtask

  task automatic test_two_port;
    step_t st;
    int    n = 0;
    plan_q = {};
    add(4'b0101, -1, 1); add(4'b0101, 0, 4); add(4'b0101, -1, 1);
    add(4'b0101,  2, 4); add(4'b0101, -1, 1); add(4'b0101, 0, 4);
    add(4'b0000, -1, 1);
    while (plan_q.size() != 0) begin
      st = plan_q.pop_front();
      @(negedge clk);
      req[0] = st.req;
      #1;
      total++;
      if (st.tok >= 0) begin
        if (oval_w[0] !== 1'b1 || osel_w[0] !== 2'(st.tok) || irdy_w[0] !== 4'(1 << st.tok) ||
            odat_w[0] !== exp_word(0, st.tok)) begin
          bad++;
          $display("FAIL two_port step%0d: val=%b sel=%0d rdy=%b dat=%h, want 1/%0d/%b/%h",
                   n, oval_w[0], osel_w[0], irdy_w[0], odat_w[0], st.tok, 4'(1 << st.tok), exp_word(0, st.tok));
        end
        exp_seq[0][st.tok]++;
      end else if (oval_w[0] !== 1'b0 || irdy_w[0] !== 4'b0000) begin
        bad++;
        $display("FAIL two_port step%0d: val=%b rdy=%b, want idle 0/0000", n, oval_w[0], irdy_w[0]);
      end
      n++;
    end
  endtask

  task automatic test_burst_one;
    step_t st;
    int    n = 0;
    plan_q = {};
    add(4'b1111, -1, 1);
    for (int k = 0; k < 4; k++) begin
      add(4'b1111, k, 1);
      add(4'b1111, -1, 1);
    end
    add(4'b1111, 0, 1);
    add(4'b0000, -1, 1);
    while (plan_q.size() != 0) begin
      st = plan_q.pop_front();
      @(negedge clk);
      req[1] = st.req;
      #1;
      total++;
      if (st.tok >= 0) begin
        if (oval_w[1] !== 1'b1 || osel_w[1] !== 2'(st.tok) || irdy_w[1] !== 4'(1 << st.tok) ||
            odat_w[1] !== exp_word(1, st.tok)) begin
          bad++;
          $display("FAIL burst_one step%0d: val=%b sel=%0d rdy=%b dat=%h, want 1/%0d/%b/%h",
                   n, oval_w[1], osel_w[1], irdy_w[1], odat_w[1], st.tok, 4'(1 << st.tok), exp_word(1, st.tok));
        end
        exp_seq[1][st.tok]++;
      end else if (oval_w[1] !== 1'b0 || irdy_w[1] !== 4'b0000) begin
        bad++;
        $display("FAIL burst_one step%0d: val=%b rdy=%b, want idle 0/0000", n, oval_w[1], irdy_w[1]);
      end
      n++;
    end
  endtask

  task automatic test_early_release;
    step_t st;
    int    n = 0;
    plan_q = {};
    add(4'b0010, -1, 1); add(4'b1010, 1, 2); add(4'b1000, -2, 1);
    add(4'b1000, -1, 1); add(4'b1000, 3, 16); add(4'b0000, -1, 1);
    while (plan_q.size() != 0) begin
      st = plan_q.pop_front();
      @(negedge clk);
      req[2] = st.req;
      #1;
      total++;
      if (st.tok >= 0) begin
        if (oval_w[2] !== 1'b1 || osel_w[2] !== 2'(st.tok) || irdy_w[2] !== 4'(1 << st.tok) ||
            odat_w[2] !== exp_word(2, st.tok)) begin
          bad++;
          $display("FAIL early_release step%0d: val=%b sel=%0d rdy=%b dat=%h, want 1/%0d/%b/%h",
                   n, oval_w[2], osel_w[2], irdy_w[2], odat_w[2], st.tok, 4'(1 << st.tok), exp_word(2, st.tok));
        end
        exp_seq[2][st.tok]++;
      end else if (st.tok == -2) begin
        if (oval_w[2] !== 1'b0 || osel_w[2] !== 2'd1) begin
          bad++;
          $display("FAIL early_release drop step%0d: val=%b sel=%0d, want 0/1", n, oval_w[2], osel_w[2]);
        end
      end else if (oval_w[2] !== 1'b0 || irdy_w[2] !== 4'b0000) begin
        bad++;
        $display("FAIL early_release step%0d: val=%b rdy=%b, want idle 0/0000", n, oval_w[2], irdy_w[2]);
      end
      n++;
    end
  endtask

  task automatic test_backpressure;
    int cur_cnt  = 0;
    int cur_port = 0;
    bit in_grant = 1'b0;
    grant_q = '{0, 1, 3};
    @(negedge clk);
    req[3] = 4'b1011;
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      ordy[3] = 1'($urandom_range(0, 1));
      #1;
      if (oval_w[3] === 1'b1) begin
        if (!in_grant) begin
          cur_port = grant_q.pop_front();
          grant_q.push_back(cur_port);
          in_grant = 1'b1;
          cur_cnt  = 0;
          total++;
          if (osel_w[3] !== 2'(cur_port)) begin
            bad++;
            $display("FAIL bp grant order cyc%0d: o_sel=%0d, want %0d", c, osel_w[3], cur_port);
          end
        end
        total++;
        if (ordy[3]) begin
          cur_cnt++;
          if (osel_w[3] !== 2'(cur_port) || irdy_w[3] !== 4'(1 << cur_port) ||
              odat_w[3] !== exp_word(3, cur_port) || cur_cnt > 8) begin
            bad++;
            $display("FAIL bp xfer cyc%0d: sel=%0d rdy=%b dat=%h n=%0d, want %0d/%b/%h n<=8",
                     c, osel_w[3], irdy_w[3], odat_w[3], cur_cnt, cur_port, 4'(1 << cur_port), exp_word(3, cur_port));
          end
          exp_seq[3][cur_port]++;
        end else if (irdy_w[3] !== 4'b0000) begin
          bad++;
          $display("FAIL bp stall cyc%0d: i_rdy=%b with o_rdy=0, want 0000", c, irdy_w[3]);
        end
      end else begin
        total++;
        if (irdy_w[3] !== 4'b0000) begin
          bad++;
          $display("FAIL bp idle cyc%0d: i_rdy=%b, want 0000", c, irdy_w[3]);
        end
        if (in_grant) begin
          total++;
          if (cur_cnt != 8) begin
            bad++;
            $display("FAIL bp burst len cyc%0d: port %0d sent %0d words, want 8", c, cur_port, cur_cnt);
          end
          in_grant = 1'b0;
        end
      end
    end
    @(negedge clk);
    req[3] = 4'b0000;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset_mid_burst;
    ordy[3] = 1'b1;
    @(negedge clk);
    rst[3] = 1'b1;
    @(negedge clk);
    rst[3] = 1'b0;
    req[3] = 4'b0010;
    #1;
    total++;
    if (oval_w[3] !== 1'b0) begin
      bad++;
      $display("FAIL mid_reset pre: o_val=%b, want 0", oval_w[3]);
    end
    // Six words: the sixth is on the bus while cnt = 5 and reset is raised.
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (k == 5) begin
        rst[3] = 1'b1;
        req[3] = 4'b0011;
      end
      #1;
      total++;
      if (oval_w[3] !== 1'b1 || osel_w[3] !== 2'd1 || odat_w[3] !== exp_word(3, 1)) begin
        bad++;
        $display("FAIL mid_reset word%0d: val=%b sel=%0d dat=%h, want 1/1/%h",
                 k, oval_w[3], osel_w[3], odat_w[3], exp_word(3, 1));
      end
      exp_seq[3][1]++;
    end
    @(negedge clk);
    rst[3] = 1'b0;
    #1;
    total++;
    if (oval_w[3] !== 1'b0 || irdy_w[3] !== 4'b0000) begin
      bad++;
      $display("FAIL mid_reset after: val=%b rdy=%b, want 0/0000", oval_w[3], irdy_w[3]);
    end
    @(negedge clk);
    #1;
    total++;
    if (oval_w[3] !== 1'b1 || osel_w[3] !== 2'd0 || odat_w[3] !== exp_word(3, 0)) begin
      bad++;
      $display("FAIL mid_reset regrant: val=%b sel=%0d dat=%h, want 1/0/%h",
               oval_w[3], osel_w[3], odat_w[3], exp_word(3, 0));
    end
    exp_seq[3][0]++;
    @(negedge clk);
    req[3] = 4'b0000;
    #1;
    total++;
    if (oval_w[3] !== 1'b0) begin
      bad++;
      $display("FAIL mid_reset drop: o_val=%b, want 0", oval_w[3]);
    end
    repeat (2) @(negedge clk);
  endtask

  initial begin
    for (int i = 0; i < NI; i++) begin
      rst[i]  = 1'b1;
      req[i]  = 4'b0000;
      ordy[i] = 1'b0;
      for (int p = 0; p < 4; p++) exp_seq[i][p] = 6'd0;
    end
    test_reset();
    test_two_port();
    test_burst_one();
    test_early_release();
    test_backpressure();
    test_reset_mid_burst();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
